fetch_unit: RTL and testbench

//  Fetch stage of the 5-stage pipelined cpu. Owns the PC and issues word-indexed requests to a

---
 rtl/fetch_unit_if.sv | 34 +++
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit_if                                                            |
// | Bundles the imem bus, decode hand-off and EX redirect of the fetch stage.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface fetch_unit_if #(
    parameter int XLEN    = 32,
    parameter int PC_BITS = 5,
    parameter int CNT_W   = 32
);
    logic               imem_en;
    logic [PC_BITS-1:0] imem_addr;
    logic [XLEN-1:0]    imem_rdata;
    logic               stall_D;
    logic               EX_taken;
    logic [PC_BITS-1:0] EX_target;
    logic               F_valid;
    logic [PC_BITS-1:0] F_pc;
    logic [XLEN-1:0]    F_inst;
    logic [CNT_W-1:0]   perf_fetched;
    logic [CNT_W-1:0]   perf_bubbles;

    modport master (
        output imem_en, imem_addr, F_valid, F_pc, F_inst, perf_fetched, perf_bubbles,
        input  imem_rdata, stall_D, EX_taken, EX_target
    );

    modport slave (
        input  imem_en, imem_addr, F_valid, F_pc, F_inst, perf_fetched, perf_bubbles,
        output imem_rdata, stall_D, EX_taken, EX_target
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit                                                               |
// | PC owner and 2-entry fetch queue feeding decode from a 1-cycle imem.     |
// | Optional performance counters enabled by FETCH_PERF_CNT_EN.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_unit #(
    parameter int XLEN    = 32,
    parameter int PC_BITS = 5,
    parameter int CNT_W   = 32
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    localparam logic [PC_BITS-1:0] c_PC_ONE = {{(PC_BITS-1){1'b0}}, 1'b1};

    logic [1:0]         count_q, count_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               inflight_q, inflight_d;
    logic [PC_BITS-1:0] pc_req_q, pc_req_d;
    logic [PC_BITS-1:0] tag_q, tag_d;
    logic [PC_BITS-1:0] q_pc_q   [2];
    logic [PC_BITS-1:0] q_pc_d   [2];
    logic [XLEN-1:0]    q_inst_q [2];
    logic [XLEN-1:0]    q_inst_d [2];

    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    logic [2:0]         w_occ;

    always_comb begin
        w_valid = (count_q != 2'd0);
        w_pop   = w_valid & ~bus.stall_D & ~bus.EX_taken;
        w_push  = inflight_q & ~bus.EX_taken;
        // Slots already committed after this cycle's pop; issue only if one stays free.
        w_occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_pop};
        w_issue = ~rst & ~bus.EX_taken & (w_occ < 3'd2);

        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        inflight_d = inflight_q;
        pc_req_d   = pc_req_q;
        tag_d      = tag_q;
        q_pc_d     = q_pc_q;
        q_inst_d   = q_inst_q;

        if (bus.EX_taken) begin
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            inflight_d = 1'b0;
            pc_req_d   = bus.EX_target;
        end else begin
            if (w_push) begin
                q_pc_d[wr_ptr_q]   = tag_q;
                q_inst_d[wr_ptr_q] = bus.imem_rdata;
                wr_ptr_d           = ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d    = count_q + {1'b0, w_push} - {1'b0, w_pop};
            inflight_d = w_issue;
            if (w_issue) begin
                pc_req_d = pc_req_q + c_PC_ONE;
                tag_d    = pc_req_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            inflight_q <= 1'b0;
            pc_req_q   <= '0;
            tag_q      <= '0;
            for (int i = 0; i < 2; i++) begin
                q_pc_q[i]   <= '0;
                q_inst_q[i] <= '0;
            end
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            inflight_q <= inflight_d;
            pc_req_q   <= pc_req_d;
            tag_q      <= tag_d;
            q_pc_q     <= q_pc_d;
            q_inst_q   <= q_inst_d;
        end
    end

    assign bus.imem_en   = w_issue;
    assign bus.imem_addr = pc_req_q;
    assign bus.F_valid   = w_valid;
    assign bus.F_pc      = q_pc_q[rd_ptr_q];
    assign bus.F_inst    = w_valid ? q_inst_q[rd_ptr_q] : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] fetched_q, fetched_d;
    logic [CNT_W-1:0] bubbles_q, bubbles_d;

    always_comb begin
        fetched_d = fetched_q + {{(CNT_W-1){1'b0}}, w_pop};
        bubbles_d = bubbles_q + {{(CNT_W-1){1'b0}}, (~w_valid & ~bus.stall_D)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q <= '0;
            bubbles_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            bubbles_q <= bubbles_d;
        end
    end

    assign bus.perf_fetched = fetched_q;
    assign bus.perf_bubbles = bubbles_q;
`else
    assign bus.perf_fetched = {CNT_W{1'b0}};
    assign bus.perf_bubbles = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_unit                                                            |
// | Cycle table plus scoreboard of delivered PCs for fetch_unit.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fetch_unit;
    localparam int XLEN    = 32;
    localparam int PC_BITS = 5;
    localparam int CNT_W   = 32;

    logic clk = 1'b0;
    logic rst;

    fetch_unit_if #(.XLEN(XLEN), .PC_BITS(PC_BITS), .CNT_W(CNT_W)) bus ();

    fetch_unit #(.XLEN(XLEN), .PC_BITS(PC_BITS), .CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // imem[i] = 0x100 + i; non-requested cycles return junk that must never be queued
    always @(posedge clk)
        bus.imem_rdata <= bus.imem_en ? (32'h100 + {27'd0, bus.imem_addr}) : 32'hBAD0_0000;

    typedef struct {
        logic       rst, stall, ex;
        logic [4:0] tgt;
        logic       en;
        logic [4:0] addr;
        logic       chk_a;
        logic       chk_f;
        logic       valid;
        logic [4:0] pc;
        logic [1:0] perf;
    } vec_t;

    vec_t       vecs[$];
    logic [4:0] sb[$];
    int         total = 0;
    int         bad   = 0;
    int         exp_pops = 0;
    int         exp_bub  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_reset(input logic [4:0] start);
        sb.delete();
        for (int k = 0; k < 400; k++) sb.push_back(start + 5'(k));
    endtask

    task automatic sb_pop_check();
        logic [4:0] e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: got pop expected none");
        end else begin
            e = sb.pop_front();
            chk("pop_pc", {27'd0, bus.F_pc}, {27'd0, e});
            chk("pop_inst", bus.F_inst, 32'h100 + {27'd0, e});
        end
    endtask

    task automatic chk_perf(input int fetched, input int bubbles);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", bus.perf_fetched, fetched);
        chk("perf_bubbles", bus.perf_bubbles, bubbles);
`else
        chk("perf_fetched_off", bus.perf_fetched, 32'd0 & fetched);
        chk("perf_bubbles_off", bus.perf_bubbles, 32'd0 & bubbles);
`endif
    endtask

    function automatic void add(input logic r, input logic s, input logic e, input logic [4:0] t,
                                input logic en, input logic [4:0] a, input logic ca,
                                input logic cf, input logic va, input logic [4:0] pc,
                                input logic [1:0] pf);
        vec_t v;
        v.rst = r; v.stall = s; v.ex = e; v.tgt = t;
        v.en = en; v.addr = a; v.chk_a = ca;
        v.chk_f = cf; v.valid = va; v.pc = pc; v.perf = pf;
        vecs.push_back(v);
    endfunction

    initial begin
        int nstall_free;
        rst = 1'b1;
        bus.stall_D = 1'b0;
        bus.EX_taken = 1'b0;
        bus.EX_target = '0;

        //  rst stl ex tgt    en addr ca  cf v  pc  perf
        add(1, 0, 0, 5'd0,   0, 5'd0,  1, 1, 0, 5'd0, 0);   // reset held
        add(1, 0, 0, 5'd0,   0, 5'd0,  1, 1, 0, 5'd0, 0);
        add(0, 0, 0, 5'd0,   1, 5'd0,  1, 1, 0, 5'd0, 0);   // first issue at 0
        add(0, 0, 0, 5'd0,   1, 5'd1,  1, 1, 0, 5'd0, 0);
        add(0, 0, 0, 5'd0,   1, 5'd2,  1, 1, 1, 5'd0, 0);   // PC 0 delivered
        add(0, 0, 0, 5'd0,   1, 5'd3,  1, 1, 1, 5'd1, 0);
        add(0, 0, 0, 5'd0,   1, 5'd4,  1, 1, 1, 5'd2, 0);
        add(0, 1, 0, 5'd0,   0, 5'd5,  1, 1, 1, 5'd3, 0);   // stall 4 cycles at PC 3
        add(0, 1, 0, 5'd0,   0, 5'd5,  1, 1, 1, 5'd3, 0);
        add(0, 1, 0, 5'd0,   0, 5'd5,  1, 1, 1, 5'd3, 0);
        add(0, 1, 0, 5'd0,   0, 5'd5,  1, 1, 1, 5'd3, 0);
        add(0, 0, 0, 5'd0,   1, 5'd5,  1, 1, 1, 5'd3, 0);
        add(0, 0, 0, 5'd0,   1, 5'd6,  1, 1, 1, 5'd4, 0);
        add(0, 0, 0, 5'd0,   1, 5'd7,  1, 1, 1, 5'd5, 0);
        add(0, 1, 0, 5'd0,   0, 5'd8,  1, 1, 1, 5'd6, 0);   // fill queue
        add(0, 1, 0, 5'd0,   0, 5'd8,  1, 1, 1, 5'd6, 0);
        add(0, 1, 1, 5'd17,  0, 5'd8,  1, 1, 1, 5'd6, 0);   // redirect, full + stalled
        add(0, 0, 0, 5'd0,   1, 5'd17, 1, 1, 0, 5'd0, 0);
        add(0, 0, 0, 5'd0,   1, 5'd18, 1, 1, 0, 5'd0, 0);
        add(0, 0, 0, 5'd0,   1, 5'd19, 1, 1, 1, 5'd17, 0);
        add(0, 0, 0, 5'd0,   1, 5'd20, 1, 1, 1, 5'd18, 0);
        add(0, 0, 1, 5'd30,  0, 5'd21, 1, 1, 1, 5'd19, 0);  // redirect near wrap
        add(0, 0, 0, 5'd0,   1, 5'd30, 1, 1, 0, 5'd0, 0);
        add(0, 0, 0, 5'd0,   1, 5'd31, 1, 1, 0, 5'd0, 0);
        add(0, 0, 0, 5'd0,   1, 5'd0,  1, 1, 1, 5'd30, 0);
        add(0, 0, 0, 5'd0,   1, 5'd1,  1, 1, 1, 5'd31, 0);
        add(0, 0, 0, 5'd0,   1, 5'd2,  1, 1, 1, 5'd0, 0);
        add(0, 0, 0, 5'd0,   1, 5'd3,  1, 1, 1, 5'd1, 0);
        add(0, 0, 1, 5'd10,  0, 5'd4,  1, 1, 1, 5'd2, 0);   // back-to-back redirects
        add(0, 0, 1, 5'd12,  0, 5'd10, 1, 1, 0, 5'd0, 0);
        add(0, 0, 0, 5'd0,   1, 5'd12, 1, 1, 0, 5'd0, 0);
        add(0, 0, 0, 5'd0,   1, 5'd13, 1, 1, 0, 5'd0, 0);
        add(0, 0, 0, 5'd0,   1, 5'd14, 1, 1, 1, 5'd12, 0);
        add(0, 0, 0, 5'd0,   1, 5'd15, 1, 1, 1, 5'd13, 0);
        add(1, 0, 0, 5'd0,   0, 5'd0,  0, 0, 0, 5'd0, 1);   // mid-run reset, request in flight
        add(0, 0, 0, 5'd0,   1, 5'd0,  1, 1, 0, 5'd0, 2);
        add(0, 0, 0, 5'd0,   1, 5'd1,  1, 1, 0, 5'd0, 0);
        add(0, 0, 0, 5'd0,   1, 5'd2,  1, 1, 1, 5'd0, 0);
        add(0, 0, 0, 5'd0,   1, 5'd3,  1, 1, 1, 5'd1, 0);

        @(posedge clk);
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            rst           = vecs[i].rst;
            bus.stall_D   = vecs[i].stall;
            bus.EX_taken  = vecs[i].ex;
            bus.EX_target = vecs[i].tgt;
            if (vecs[i].rst)     sb_reset(5'd0);
            else if (vecs[i].ex) sb_reset(vecs[i].tgt);
            @(negedge clk);
            chk($sformatf("en[%0d]", i), {31'd0, bus.imem_en}, {31'd0, vecs[i].en});
            if (vecs[i].chk_a)
                chk($sformatf("addr[%0d]", i), {27'd0, bus.imem_addr}, {27'd0, vecs[i].addr});
            if (vecs[i].chk_f) begin
                chk($sformatf("valid[%0d]", i), {31'd0, bus.F_valid}, {31'd0, vecs[i].valid});
                if (vecs[i].valid)
                    chk($sformatf("pc[%0d]", i), {27'd0, bus.F_pc}, {27'd0, vecs[i].pc});
                else
                    chk($sformatf("nop[%0d]", i), bus.F_inst, 32'd0);
            end
            if (vecs[i].valid & ~vecs[i].stall & ~vecs[i].ex & ~vecs[i].rst) begin
                sb_pop_check();
                exp_pops++;
            end
            if (~vecs[i].rst & ~vecs[i].valid & ~vecs[i].stall) exp_bub++;
            if (vecs[i].perf == 2'd1) chk_perf(exp_pops, exp_bub);
            if (vecs[i].perf == 2'd2) chk_perf(0, 0);
            if (vecs[i].rst) begin
                exp_pops = 0;
                exp_bub  = 0;
            end
        end

        // Random decode stalls on a running stream: valid never drops, head held while stalled
        nstall_free = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            rst          = 1'b0;
            bus.EX_taken = 1'b0;
            bus.stall_D  = ($urandom_range(0, 9) < 4);
            @(negedge clk);
            chk("rand_valid", {31'd0, bus.F_valid}, 32'd1);
            if (bus.stall_D) begin
                if (sb.size() != 0) chk("hold_pc", {27'd0, bus.F_pc}, {27'd0, sb[0]});
            end else begin
                sb_pop_check();
                nstall_free++;
                exp_pops++;
            end
        end
        @(posedge clk); #1;
        bus.stall_D = 1'b1;
        @(negedge clk);
        chk_perf(exp_pops, exp_bub);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
